// File: rtl/baby_io_pkg.sv
// Shared definitions for the Manchester Baby byte-wide I/O blocks.
// Word/byte widths and the two-state transfer FSM encoding.
package baby_io_pkg;

    localparam int unsigned BABY_WORD_W = 32;
    localparam int unsigned BABY_BYTE_W = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } baby_io_state_e;

endpackage

// File: rtl/ptp_b.sv
// Word-to-byte serializer for the Baby RAM data output side. Each word is presented as
// NBYTES bytes with a per-byte valid/ack handshake, most significant byte first by default.
module ptp_b
    import baby_io_pkg::*;
#(
    parameter int unsigned WORD_W    = BABY_WORD_W,
    parameter int unsigned BYTE_W    = BABY_BYTE_W,
    parameter bit          MSB_FIRST = 1'b1,
    localparam int unsigned NBYTES   = WORD_W / BYTE_W,
    localparam int unsigned IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic              load_i,
    output logic              ready_o,
    output logic [BYTE_W-1:0] byte_o,
    output logic              byte_valid_o,
    input  logic              byte_ack_i,
    output logic [IDX_W-1:0]  byte_idx_o,
    output logic              done_o,
    output logic              overrun_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    baby_io_state_e    state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [WORD_W-1:0] shift_next;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;

    // The register shifts on every ack, including the last, so it is empty again
    // by the time the block returns to IDLE and byte_o reads zero when idle.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign byte_o     = shift_q[WORD_W-1 -: BYTE_W];
            assign shift_next = shift_q << BYTE_W;
        end else begin : g_lsb_first
            assign byte_o     = shift_q[BYTE_W-1:0];
            assign shift_next = shift_q >> BYTE_W;
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        overrun_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_i) begin
                    shift_d = word_i;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                // A load while busy is flagged and dropped; the transfer carries on.
                overrun_d = load_i;
                if (byte_ack_i) begin
                    shift_d = shift_next;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            idx_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign ready_o      = (state_q == IDLE);
    assign byte_valid_o = (state_q == SEND);
    assign byte_idx_o   = idx_q;
    assign done_o       = done_q;
    assign overrun_o    = overrun_q;

endmodule
